// File: rtl/uart_rx_framer_if.sv
// Serial line plus received-frame reporting for uart_rx_framer.
// master: drives serial_in and observes results (line side / testbench).
// slave:  the receiver itself.
interface uart_rx_framer_if #(
  parameter int unsigned INPUT_DATA_WIDTH = 8
);
  logic                        serial_in;
  logic [INPUT_DATA_WIDTH-1:0] received_data;
  logic                        data_is_valid;
  logic                        rx_error;
  logic                        framing_error;
  logic                        rx_busy;

  modport master (
    output serial_in,
    input  received_data, data_is_valid, rx_error, framing_error, rx_busy
  );

  modport slave (
    input  serial_in,
    output received_data, data_is_valid, rx_error, framing_error, rx_busy
  );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receiver: oversamples serial_in, reassembles LSB-first frames
// (start, data, optional parity, stop) and reports one-cycle valid,
// parity-error or framing-error pulses.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit decision becomes a
// 2-of-3 vote over the three samples around mid-bit (same decision timing).
module uart_rx_framer #(
  parameter int unsigned INPUT_DATA_WIDTH           = 8,
  parameter int unsigned PARITY_ENABLED             = 1,
  parameter int unsigned PARITY_TYPE                = 0,
  parameter int unsigned CLOCKS_PER_BIT             = 8,
  parameter int unsigned NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_framer_if.slave rx
);

  localparam int unsigned W     = INPUT_DATA_WIDTH;
  localparam int unsigned N     = NUMBER_OF_RX_SYNCHRONIZERS;
  localparam int unsigned CW    = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned HALF  = CLOCKS_PER_BIT / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state, state_n;
  logic [N-1:0]    sync;
  logic            s_sync;
  logic [CW-1:0]   count, count_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [W-1:0]    shreg, shreg_n;
  logic [W:0]      shift_tmp;
  logic            par_bit, par_bit_n;
  logic [W-1:0]    data_q, data_n;
  logic            valid_q, valid_n;
  logic            perr_q, perr_n;
  logic            ferr_q, ferr_n;
  logic            h_mid;
  logic            bit_dec;
  logic            at_decide;
  logic            parity_ok;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic            h_pre;
`endif

  assign s_sync    = sync[N-1];
  assign at_decide = (count == CW'(HALF + 1));
  assign shift_tmp = {bit_dec, shreg};
  assign parity_ok = (PARITY_ENABLED == 0) ||
                     (par_bit == ((^shreg) ^ (PARITY_TYPE != 0)));

`ifdef UART_RX_MAJORITY_VOTE_EN
  assign bit_dec = (h_pre & h_mid) | (h_pre & s_sync) | (h_mid & s_sync);
`else
  assign bit_dec = h_mid;
`endif

  assign rx.received_data = data_q;
  assign rx.data_is_valid = valid_q;
  assign rx.rx_error      = perr_q;
  assign rx.framing_error = ferr_q;
  assign rx.rx_busy       = (state != IDLE);

  // Synchronizer chain on the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (reset) sync <= '1;
    else       sync <= {sync[N-2:0], rx.serial_in};
  end

  // Capture the samples leading up to the decision point.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_mid <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      h_pre <= 1'b1;
`endif
    end else begin
      if (count == CW'(HALF)) h_mid <= s_sync;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (count == CW'(HALF - 1)) h_pre <= s_sync;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
    end
  end

  // Next-state, bit assembly and result pulses.
  always_comb begin
    state_n   = state;
    count_n   = (count == CW'(CLOCKS_PER_BIT - 1)) ? '0 : count + CW'(1);
    idx_n     = idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    data_n    = data_q;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        // The cycle that sees the falling edge is sample 0 of the start bit,
        // so START begins at count 1; decisions then land on count HALF+1.
        count_n = CW'(1);
        if (!s_sync) state_n = START;
      end
      START: begin
        if (at_decide) begin
          if (bit_dec) state_n = IDLE;
          else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
      end
      DATA: begin
        if (at_decide) begin
          shreg_n = shift_tmp[W:1];
          if (idx == IDX_W'(W - 1)) state_n = (PARITY_ENABLED != 0) ? PARITY : STOP;
          else                      idx_n   = idx + IDX_W'(1);
        end
      end
      PARITY: begin
        if (at_decide) begin
          par_bit_n = bit_dec;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (at_decide) begin
          if (bit_dec) begin
            state_n = IDLE;
            if (parity_ok) begin
              data_n  = shreg;
              valid_n = 1'b1;
            end else begin
              perr_n = 1'b1;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (s_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
